arbitro_rr_8a1: RTL and testbench

Eight-to-one round-robin arbiter between the eight per-class input FIFOs and the single downstream FIFO. It pops one word per cycle from a non-empty input FIFO and pushes it downstream with one cycle of latency. It throttles itself using hysteresis on the downstream FIFO occupancy against the low/high thresholds. It runs only while the control FSM reports not-idle; that FSM supplies the `umbral_L`/`umbral_H` values and the `idle` indication.

---
 rtl/arbitro_rr_8a1.sv | 117 +++++++++++
 tb/tb_arbitro_rr_8a1.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_8a1.sv
// Eight-to-one arbiter draining per-class FIFOs into one downstream FIFO, throttled by occupancy hysteresis.
// Build option: define ARB_STRICT_PRIORITY_EN for fixed priority (FIFO 0 highest) instead of round-robin.
module arbitro_rr_8a1 #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned UMBRALES_L_H = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      idle,
    input  logic [UMBRALES_L_H-1:0]   umbral_L,
    input  logic [UMBRALES_L_H-1:0]   umbral_H,
    input  logic [7:0]                empty_fifos,
    input  logic [8*DATA_WIDTH-1:0]   data_fifos,
    input  logic [UMBRALES_L_H-1:0]   dest_count,
    output logic [7:0]                pop,
    output logic                      push,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [2:0]                grant_idx,
    output logic                      pause
);

    localparam int unsigned NUM_FIFOS = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    below_h;
    logic                    at_or_below_l;
    logic                    found;
    logic [IDX_W-1:0]        grant_sel;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   head_words [NUM_FIFOS];

    assign below_h       = (dest_count < umbral_H);
    assign at_or_below_l = (dest_count <= umbral_L);

    // Unpack the FWFT head words so the grant can select one directly
    always_comb begin
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            head_words[i] = data_fifos[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First non-empty FIFO after the last grant (or from 0 in strict-priority builds)
    always_comb begin
        grant_sel = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
`ifdef ARB_STRICT_PRIORITY_EN
            idx = IDX_W'(k);
`else
            idx = grant_idx + IDX_W'(k + 1);
`endif
            if (!found && !empty_fifos[idx]) begin
                grant_sel = idx;
                found     = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; idle overrides everything, 2'b11 falls back to IDLE
    always_comb begin
        state_d = state_q;
        if (idle) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (!below_h) state_d = PAUSE;
                PAUSE:   if (at_or_below_l && below_h) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Combinational read strobe; the high-threshold guard stops pops in the same cycle
    always_comb begin
        pop = '0;
        if ((state_q == RUN) && !idle && below_h && found) begin
            pop[grant_sel] = 1'b1;
        end
    end

    // Registered push side: one cycle behind the pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push      <= 1'b0;
            data_out  <= '0;
            grant_idx <= IDX_W'(NUM_FIFOS - 1);
            pause     <= 1'b0;
        end else begin
            push  <= |pop;
            pause <= (state_d == PAUSE);
            if (|pop) begin
                data_out  <= head_words[grant_sel];
                grant_idx <= grant_sel;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr_8a1.sv
// Randomized and directed bench for arbitro_rr_8a1 against a queue-based reference model.
`timescale 1ns/1ps
module tb_arbitro_rr_8a1;

    localparam int unsigned DW = 10;
    localparam int unsigned CW = 8;
    localparam int          NF = 8;
    localparam int          QD = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              idle;
    logic [CW-1:0]     umbral_L;
    logic [CW-1:0]     umbral_H;
    logic [7:0]        empty_fifos;
    logic [NF*DW-1:0]  data_fifos;
    logic [CW-1:0]     dest_count;
    logic [7:0]        pop;
    logic              push;
    logic [DW-1:0]     data_out;
    logic [2:0]        grant_idx;
    logic              pause;

    arbitro_rr_8a1 #(.DATA_WIDTH(DW), .UMBRALES_L_H(CW)) dut (
        .clk(clk), .reset(reset), .idle(idle),
        .umbral_L(umbral_L), .umbral_H(umbral_H),
        .empty_fifos(empty_fifos), .data_fifos(data_fifos), .dest_count(dest_count),
        .pop(pop), .push(push), .data_out(data_out), .grant_idx(grant_idx), .pause(pause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Input FIFO contents as circular buffers
    logic [DW-1:0] mem [NF][QD];
    int rd [NF];
    int wr [NF];
    int total_loaded = 0;
    int pushed_seen  = 0;

    // Reference model: 0 = idle, 1 = running, 2 = paused
    int            m_state;
    int            m_last;
    logic          m_push;
    logic [DW-1:0] m_data;
    logic          m_pause;
    int            pend_g = -1;
    logic [7:0]    last_pop;
    int            cfg_l = 2;
    int            cfg_h = 6;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int occ(input int i);
        return wr[i] - rd[i];
    endfunction

    function automatic int remaining();
        int s = 0;
        for (int i = 0; i < NF; i++) s += occ(i);
        return s;
    endfunction

    task automatic load(input int i, input logic [DW-1:0] w);
        mem[i][wr[i] % QD] = w;
        wr[i]++;
        total_loaded++;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_last  = 7;
        m_push  = 1'b0;
        m_data  = '0;
        m_pause = 1'b0;
    endtask

    // One clock: check registered outputs, drive inputs at negedge, check pop, advance model
    task automatic step(input logic idle_v, input int dc_v, input logic rst_v);
        int         g;
        int         idx;
        logic [7:0] exp_pop;
        @(negedge clk);
        chk("push", 32'(push), 32'(m_push));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("grant_idx", 32'(grant_idx), 32'(m_last));
        chk("pause", 32'(pause), 32'(m_pause));
        if (push === 1'b1) pushed_seen++;
        if (pend_g >= 0) begin
            rd[pend_g]++;
            pend_g = -1;
        end
        reset      = rst_v;
        idle       = idle_v;
        dest_count = CW'(dc_v);
        umbral_L   = CW'(cfg_l);
        umbral_H   = CW'(cfg_h);
        for (int i = 0; i < NF; i++) begin
            empty_fifos[i] = (occ(i) == 0);
            data_fifos[i*DW +: DW] = (occ(i) != 0) ? mem[i][rd[i] % QD] : DW'($urandom);
        end
        #1;
        g = -1;
        if (rst_v && m_state == 1 && !idle_v && dc_v < cfg_h) begin
            for (int k = 0; k < NF; k++) begin
`ifdef ARB_STRICT_PRIORITY_EN
                idx = k;
`else
                idx = (m_last + 1 + k) % NF;
`endif
                if (g < 0 && occ(idx) != 0) g = idx;
            end
        end
        exp_pop = '0;
        if (g >= 0) exp_pop[g] = 1'b1;
        chk("pop", 32'(pop), 32'(exp_pop));
        last_pop = pop;
        if (!rst_v) begin
            model_reset();
        end else begin
            m_push = (g >= 0);
            if (g >= 0) begin
                m_data = mem[g][rd[g] % QD];
                m_last = g;
                pend_g = g;
            end
            if (idle_v) m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (m_state == 1 && dc_v >= cfg_h) m_state = 2;
            else if (m_state == 2 && dc_v <= cfg_l && dc_v < cfg_h) m_state = 1;
            m_pause = (m_state == 2);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (remaining() != 0 && n < budget) begin
            step(1'b0, 0, 1'b1);
            n++;
        end
        if (remaining() != 0) chk("drain_timeout", 32'(remaining()), 32'd0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
    endtask

    logic [7:0] mask;

    initial begin
        for (int i = 0; i < NF; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        model_reset();
        reset       = 1'b1;
        idle        = 1'b1;
        dest_count  = '0;
        umbral_L    = CW'(2);
        umbral_H    = CW'(6);
        empty_fifos = 8'hFF;
        data_fifos  = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd7);
        chk("rst_pause", 32'(pause), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);

        // Three sparse FIFOs drained in index order
        load(0, 10'h101);
        load(3, 10'h0A3);
        load(5, 10'h255);
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        chk("tp1_idle_pop", 32'(last_pop), 32'd0);
        step(1'b0, 0, 1'b1);
        chk("tp1_pop_a", 32'(last_pop), 32'h01);
        step(1'b0, 0, 1'b1);
        chk("tp1_pop_b", 32'(last_pop), 32'h08);
        chk("tp1_word_a", 32'(data_out), 32'h101);
        step(1'b0, 0, 1'b1);
        chk("tp1_pop_c", 32'(last_pop), 32'h20);
        chk("tp1_word_b", 32'(data_out), 32'h0A3);
        step(1'b0, 0, 1'b1);
        chk("tp1_word_c", 32'(data_out), 32'h255);
        chk("tp1_push_c", 32'(push), 32'd1);
        step(1'b0, 0, 1'b1);
        chk("tp1_push_end", 32'(push), 32'd0);

        // All FIFOs busy: every 8-grant window covers all eight
        for (int i = 0; i < NF; i++) begin
            load(i, DW'($urandom));
            load(i, DW'($urandom));
        end
        mask = '0;
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 0, 1'b1);
            mask |= last_pop;
            if (c == 7 || c == 15) begin
                chk("rr_window", 32'(mask), 32'hFF);
                mask = '0;
            end
        end
        step(1'b0, 0, 1'b1);

        // Hysteresis with L=2, H=6
        for (int j = 0; j < 6; j++) begin
            load(2, DW'($urandom));
            load(4, DW'($urandom));
        end
        step(1'b0, 3, 1'b1);
        step(1'b0, 5, 1'b1);
        step(1'b0, 6, 1'b1);
        chk("hyst_pop_at_h", 32'(last_pop), 32'd0);
        step(1'b0, 4, 1'b1);
        chk("hyst_paused", 32'(pause), 32'd1);
        chk("hyst_pop_mid", 32'(last_pop), 32'd0);
        step(1'b0, 2, 1'b1);
        chk("hyst_still_paused", 32'(pause), 32'd1);
        step(1'b0, 2, 1'b1);
        chk("hyst_released", 32'(pause), 32'd0);
        chk("hyst_resume", 32'(last_pop != 8'h00), 32'd1);
        drain(100);

        // One-cycle idle pulse during a stream
        for (int j = 0; j < 4; j++) begin
            load(1, DW'($urandom));
            load(7, DW'($urandom));
        end
        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b1);
        chk("idle_pop", 32'(last_pop), 32'd0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("idle_resume", 32'(last_pop != 8'h00), 32'd1);
        drain(100);

        // Asynchronous reset while a push is in flight
        for (int j = 0; j < 3; j++) begin
            load(3, DW'($urandom));
            load(6, DW'($urandom));
        end
        step(1'b0, 0, 1'b1);
        chk("rst_mid_popped", 32'(last_pop != 8'h00), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_push", 32'(push), 32'd0);
        chk("rst_mid_data", 32'(data_out), 32'd0);
        chk("rst_mid_grant", 32'(grant_idx), 32'd7);
        chk("rst_mid_pop", 32'(pop), 32'd0);
        model_reset();
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("rst_first_grant", 32'(last_pop), 32'h08);
        drain(100);

`ifdef ARB_STRICT_PRIORITY_EN
        load(1, DW'($urandom));
        load(1, DW'($urandom));
        load(6, DW'($urandom));
        load(6, DW'($urandom));
        step(1'b0, 0, 1'b1);
        chk("strict_p0", 32'(last_pop), 32'h02);
        step(1'b0, 0, 1'b1);
        chk("strict_p1", 32'(last_pop), 32'h02);
        step(1'b0, 0, 1'b1);
        chk("strict_p2", 32'(last_pop), 32'h40);
        step(1'b0, 0, 1'b1);
        chk("strict_p3", 32'(last_pop), 32'h40);
        drain(100);
`endif

        // Random traffic, idle pulses, occupancy and thresholds (including L >= H)
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) begin
                cfg_l = int'($urandom_range(0, 9));
                cfg_h = int'($urandom_range(0, 9));
            end
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 3) == 0 && occ(i) < QD - 4) load(i, DW'($urandom));
            end
            step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 9)), 1'b1);
        end
        cfg_l = 2;
        cfg_h = 6;
        drain(600);

        // Every loaded word appears exactly once, except the one dropped by the mid-transfer reset
        chk("conservation", 32'(pushed_seen), 32'(total_loaded - 1 - remaining()));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
